// File: rtl/dcache_repair_arbiter.sv
// Data-cache miss-repair responder: grants one read/write repair at a time, fetches the block from L2,
// fills the cache and pulses repair_resolved. Optional L2 timeout/retry under DCACHE_ARB_TIMEOUT_EN.
module dcache_repair_arbiter #(
  parameter int BLOCK_BITS     = 1024,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    read_repair_request,
  input  logic                    write_repair_request,
  input  logic [ADDR_W-1:0]       missed_addr,
  output logic                    read_repair_req_acq,
  output logic                    write_repair_req_acq,
  output logic                    repair_resolved,
  output logic                    waddr_valid,
  output logic [ADDR_W-1:0]       waddr,
  output logic [BLOCK_BITS-1:0]   wdata,
  output logic [BLOCK_BITS/8-1:0] wmask,
  output logic                    l2_req_valid,
  input  logic                    l2_req_ready,
  output logic [ADDR_W-1:0]       l2_req_addr,
  input  logic                    l2_resp_valid,
  input  logic [BLOCK_BITS-1:0]   l2_resp_data,
  output logic                    timeout_err
);

  localparam int MASK_W = BLOCK_BITS / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_L2_REQ,
    S_L2_WAIT,
    S_FILL,
    S_RESOLVE
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    r_is_write;
  logic                    r_last_write;
  logic [ADDR_W-1:0]       r_addr;
  logic [BLOCK_BITS-1:0]   r_fill_data;
  logic                    w_any_req;
  logic                    w_grant_write;
  logic                    w_timeout;
  logic [ADDR_W-1:0]       w_addr_aligned;

  assign w_any_req      = read_repair_request | write_repair_request;
  // On contention the type that did not win last time gets the grant.
  assign w_grant_write  = write_repair_request & (~read_repair_request | ~r_last_write);
  assign w_addr_aligned = missed_addr & ~ADDR_W'(MASK_W - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_any_req) w_state_next = S_L2_REQ;
      S_L2_REQ:  if (l2_req_ready) w_state_next = S_L2_WAIT;
      S_L2_WAIT: begin
        if (l2_resp_valid) begin
          w_state_next = S_FILL;
        end else if (w_timeout) begin
          w_state_next = S_L2_REQ;
        end
      end
      S_FILL:    w_state_next = S_RESOLVE;
      S_RESOLVE: w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_write   <= 1'b0;
      r_last_write <= 1'b1;
      r_addr       <= '0;
      r_fill_data  <= '0;
    end else begin
      if (r_state == S_IDLE && w_any_req) begin
        r_is_write   <= w_grant_write;
        r_last_write <= w_grant_write;
        r_addr       <= w_addr_aligned;
      end
      if (r_state == S_L2_WAIT && l2_resp_valid) begin
        r_fill_data <= l2_resp_data;
      end
    end
  end

`ifdef DCACHE_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_timeout_err;

  assign w_timeout = (r_state == S_L2_WAIT) && !l2_resp_valid &&
                     (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counter is held at zero while requesting so every L2_WAIT visit starts fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == S_L2_REQ) begin
        r_wait_cnt <= '0;
      end else if (r_state == S_L2_WAIT) begin
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_timeout   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    read_repair_req_acq  = 1'b0;
    write_repair_req_acq = 1'b0;
    if (r_state != S_IDLE) begin
      read_repair_req_acq  = ~r_is_write;
      write_repair_req_acq = r_is_write;
    end
    l2_req_valid    = (r_state == S_L2_REQ);
    l2_req_addr     = r_addr;
    waddr_valid     = (r_state == S_FILL);
    waddr           = r_addr;
    wdata           = r_fill_data;
    wmask           = (r_state == S_FILL) ? {MASK_W{1'b1}} : {MASK_W{1'b0}};
    repair_resolved = (r_state == S_RESOLVE);
  end

endmodule

// File: tb/tb_dcache_repair_arbiter.sv
// Scoreboard bench for dcache_repair_arbiter: fills are checked against queued expectations.
// Build with DCACHE_ARB_TIMEOUT_EN defined to also exercise the L2 timeout/retry path.
module tb_dcache_repair_arbiter;

  localparam int BB = 1024;
  localparam int AW = 32;
  localparam int MW = BB / 8;
`ifdef DCACHE_ARB_TIMEOUT_EN
  localparam int TO     = 8;
  localparam int K_LONG = 5;
`else
  localparam int TO     = 64;
  localparam int K_LONG = 10;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          read_repair_request = 1'b0;
  logic          write_repair_request = 1'b0;
  logic [AW-1:0] missed_addr = '0;
  logic          read_repair_req_acq;
  logic          write_repair_req_acq;
  logic          repair_resolved;
  logic          waddr_valid;
  logic [AW-1:0] waddr;
  logic [BB-1:0] wdata;
  logic [MW-1:0] wmask;
  logic          l2_req_valid;
  logic          l2_req_ready = 1'b0;
  logic [AW-1:0] l2_req_addr;
  logic          l2_resp_valid = 1'b0;
  logic [BB-1:0] l2_resp_data = '0;
  logic          timeout_err;

  dcache_repair_arbiter #(
    .BLOCK_BITS(BB), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)
  ) u_dut (
    .clk(clk), .rst(rst),
    .read_repair_request(read_repair_request), .write_repair_request(write_repair_request),
    .missed_addr(missed_addr),
    .read_repair_req_acq(read_repair_req_acq), .write_repair_req_acq(write_repair_req_acq),
    .repair_resolved(repair_resolved), .waddr_valid(waddr_valid), .waddr(waddr),
    .wdata(wdata), .wmask(wmask), .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready),
    .l2_req_addr(l2_req_addr), .l2_resp_valid(l2_resp_valid), .l2_resp_data(l2_resp_data),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          is_write;
    logic [AW-1:0] addr;
    logic [BB-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t m_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [BB-1:0] rand_block();
    logic [BB-1:0] v;
    for (int i = 0; i < BB / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
    return {a[AW-1:7], 7'b0};
  endfunction

  // Scoreboard: every fill strobe pops one expected transaction.
  always @(negedge clk) begin
    if (!rst && waddr_valid) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_fill: got waddr_valid=1 waddr=%h, required no fill", waddr);
      end else begin
        m_e = sb_q.pop_front();
        $display("fill: waddr=%h type=%s", waddr, m_e.is_write ? "write" : "read");
        if (waddr !== m_e.addr) begin
          n_fail++;
          $display("FAIL fill_waddr: got %h required %h", waddr, m_e.addr);
        end
        n_checks++;
        if (wdata !== m_e.data) begin
          n_fail++;
          $display("FAIL fill_wdata: got low %h required low %h", wdata[127:0], m_e.data[127:0]);
        end
        n_checks++;
        if (wmask !== {MW{1'b1}}) begin
          n_fail++;
          $display("FAIL fill_wmask: got %h required all ones", wmask);
        end
        n_checks++;
        if ({write_repair_req_acq, read_repair_req_acq} !== {m_e.is_write, ~m_e.is_write}) begin
          n_fail++;
          $display("FAIL fill_acq: got w=%b r=%b required w=%b", write_repair_req_acq,
                   read_repair_req_acq, m_e.is_write);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({read_repair_req_acq, write_repair_req_acq, l2_req_valid, waddr_valid,
         repair_resolved, timeout_err} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 000000", {read_repair_req_acq,
               write_repair_req_acq, l2_req_valid, waddr_valid, repair_resolved, timeout_err});
    end
    n_checks++;
    if ({waddr, l2_req_addr, wmask} !== '0) begin
      n_fail++;
      $display("FAIL reset_addr: got waddr=%h l2_req_addr=%h required 0", waddr, l2_req_addr);
    end
    n_checks++;
    if (wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_wdata: got low %h required 0", wdata[127:0]);
    end
    rst = 1'b0;
    $display("reset: done");
  endtask

  task automatic test_read_miss();
    logic [BB-1:0] d;
    int acq_cycles;
    int pulses;
    d = {64{16'h7777}};
    missed_addr = 32'hAABB_CCDD;
    l2_req_ready = 1'b1;
    read_repair_request = 1'b1;
    sb_q.push_back('{is_write: 1'b0, addr: 32'hAABB_CC80, data: d});
    @(negedge clk);
    read_repair_request = 1'b0;
    n_checks++;
    if ({read_repair_req_acq, write_repair_req_acq, l2_req_valid} !== 3'b101) begin
      n_fail++;
      $display("FAIL read_grant: got r=%b w=%b l2v=%b required 1 0 1", read_repair_req_acq,
               write_repair_req_acq, l2_req_valid);
    end
    n_checks++;
    if (l2_req_addr !== 32'hAABB_CC80) begin
      n_fail++;
      $display("FAIL read_l2_addr: got %h required aabbcc80", l2_req_addr);
    end
    acq_cycles = 1;
    pulses = 0;
    for (int i = 0; i < K_LONG; i++) begin
      @(negedge clk);
      acq_cycles += int'(read_repair_req_acq);
      pulses += int'(repair_resolved);
    end
    @(negedge clk);
    acq_cycles += int'(read_repair_req_acq);
    l2_resp_valid = 1'b1;
    l2_resp_data = d;
    @(negedge clk);
    l2_resp_valid = 1'b0;
    l2_resp_data = '0;
    acq_cycles += int'(read_repair_req_acq);
    n_checks++;
    if (waddr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL read_fill_strobe: got %b required 1", waddr_valid);
    end
    @(negedge clk);
    acq_cycles += int'(read_repair_req_acq);
    pulses += int'(repair_resolved);
    @(negedge clk);
    pulses += int'(repair_resolved);
    n_checks++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL read_resolve_pulses: got %0d required 1", pulses);
    end
    n_checks++;
    if (acq_cycles != K_LONG + 4) begin
      n_fail++;
      $display("FAIL read_acq_cycles: got %0d required %0d", acq_cycles, K_LONG + 4);
    end
    n_checks++;
    if (read_repair_req_acq !== 1'b0) begin
      n_fail++;
      $display("FAIL read_acq_release: got %b required 0", read_repair_req_acq);
    end
    $display("read_miss: acq_cycles=%0d pulses=%0d", acq_cycles, pulses);
  endtask

  task automatic test_write_then_read();
    logic [AW-1:0] wa;
    logic [AW-1:0] ra;
    logic [BB-1:0] d;
    int r_seen;
    wa = $urandom;
    ra = $urandom;
    d = rand_block();
    l2_req_ready = 1'b1;
    missed_addr = wa;
    write_repair_request = 1'b1;
    sb_q.push_back('{is_write: 1'b1, addr: align(wa), data: d});
    @(negedge clk);
    write_repair_request = 1'b0;
    n_checks++;
    if ({write_repair_req_acq, read_repair_req_acq} !== 2'b10) begin
      n_fail++;
      $display("FAIL write_grant: got w=%b r=%b required 1 0", write_repair_req_acq,
               read_repair_req_acq);
    end
    @(negedge clk);
    read_repair_request = 1'b1;
    missed_addr = ra;
    r_seen = 0;
    repeat (3) begin
      @(negedge clk);
      r_seen += int'(read_repair_req_acq);
    end
    l2_resp_valid = 1'b1;
    l2_resp_data = d;
    @(negedge clk);
    l2_resp_valid = 1'b0;
    r_seen += int'(read_repair_req_acq);
    @(negedge clk);
    r_seen += int'(read_repair_req_acq);
    n_checks++;
    if ({repair_resolved, write_repair_req_acq} !== 2'b11) begin
      n_fail++;
      $display("FAIL write_resolve: got res=%b w=%b required 1 1", repair_resolved,
               write_repair_req_acq);
    end
    n_checks++;
    if (r_seen != 0) begin
      n_fail++;
      $display("FAIL read_acq_during_write: got %0d cycles required 0", r_seen);
    end
    d = rand_block();
    sb_q.push_back('{is_write: 1'b0, addr: align(ra), data: d});
    @(negedge clk);
    n_checks++;
    if ({read_repair_req_acq, write_repair_req_acq, repair_resolved} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_gap: got r=%b w=%b res=%b required 0 0 0", read_repair_req_acq,
               write_repair_req_acq, repair_resolved);
    end
    @(negedge clk);
    read_repair_request = 1'b0;
    n_checks++;
    if (read_repair_req_acq !== 1'b1) begin
      n_fail++;
      $display("FAIL pending_read_grant: got %b required 1", read_repair_req_acq);
    end
    @(negedge clk);
    l2_resp_valid = 1'b1;
    l2_resp_data = d;
    @(negedge clk);
    l2_resp_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({repair_resolved, read_repair_req_acq} !== 2'b11) begin
      n_fail++;
      $display("FAIL min_latency_resolve: got res=%b r=%b required 1 1", repair_resolved,
               read_repair_req_acq);
    end
    @(negedge clk);
    $display("write_then_read: done");
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] a;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    a = $urandom;
    missed_addr = a;
    l2_req_ready = 1'b1;
    read_repair_request = 1'b1;
    write_repair_request = 1'b1;
    sb_q.push_back('{is_write: 1'b0, addr: align(a), data: {32{32'h1234_5678}}});
    @(negedge clk);
    n_checks++;
    if ({read_repair_req_acq, write_repair_req_acq} !== 2'b10) begin
      n_fail++;
      $display("FAIL rr_first: got r=%b w=%b required 1 0", read_repair_req_acq,
               write_repair_req_acq);
    end
    @(negedge clk);
    l2_resp_valid = 1'b1;
    l2_resp_data = {32{32'h1234_5678}};
    @(negedge clk);
    l2_resp_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sb_q.push_back('{is_write: 1'b1, addr: align(a), data: {32{32'h9ABC_DEF0}}});
    @(negedge clk);
    read_repair_request = 1'b0;
    write_repair_request = 1'b0;
    n_checks++;
    if ({read_repair_req_acq, write_repair_req_acq} !== 2'b01) begin
      n_fail++;
      $display("FAIL rr_second: got r=%b w=%b required 0 1", read_repair_req_acq,
               write_repair_req_acq);
    end
    @(negedge clk);
    l2_resp_valid = 1'b1;
    l2_resp_data = {32{32'h9ABC_DEF0}};
    @(negedge clk);
    l2_resp_valid = 1'b0;
    repeat (2) @(negedge clk);
    $display("round_robin: done");
  endtask

  task automatic test_stray_resp();
    logic [BB-1:0] d;
    int bad;
    d = rand_block();
    l2_resp_valid = 1'b1;
    l2_resp_data = rand_block();
    @(negedge clk);
    l2_resp_valid = 1'b0;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      bad += int'(waddr_valid) + int'(repair_resolved);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stray_idle: got %0d strobes required 0", bad);
    end
    l2_req_ready = 1'b0;
    missed_addr = $urandom;
    read_repair_request = 1'b1;
    sb_q.push_back('{is_write: 1'b0, addr: align(missed_addr), data: d});
    @(negedge clk);
    read_repair_request = 1'b0;
    l2_resp_valid = 1'b1;
    l2_resp_data = rand_block();
    @(negedge clk);
    l2_resp_valid = 1'b0;
    n_checks++;
    if ({l2_req_valid, waddr_valid, repair_resolved} !== 3'b100) begin
      n_fail++;
      $display("FAIL stray_l2req: got l2v=%b wv=%b res=%b required 1 0 0", l2_req_valid,
               waddr_valid, repair_resolved);
    end
    l2_req_ready = 1'b1;
    @(negedge clk);
    l2_resp_valid = 1'b1;
    l2_resp_data = d;
    @(negedge clk);
    l2_resp_valid = 1'b0;
    repeat (2) @(negedge clk);
    $display("stray_resp: done");
  endtask

  task automatic test_reset_mid_op();
    int bad;
    missed_addr = $urandom;
    l2_req_ready = 1'b1;
    read_repair_request = 1'b1;
    @(negedge clk);
    read_repair_request = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({read_repair_req_acq, write_repair_req_acq, l2_req_valid, waddr_valid,
         repair_resolved, timeout_err} !== 6'b0) begin
      n_fail++;
      $display("FAIL midreset_ctrl: got r=%b w=%b l2v=%b required all 0",
               read_repair_req_acq, write_repair_req_acq, l2_req_valid);
    end
    n_checks++;
    if ({wdata, waddr, l2_req_addr, wmask} !== '0) begin
      n_fail++;
      $display("FAIL midreset_data: got waddr=%h wdata_low=%h required 0", waddr, wdata[127:0]);
    end
    @(negedge clk);
    rst = 1'b0;
    l2_resp_valid = 1'b1;
    l2_resp_data = rand_block();
    @(negedge clk);
    l2_resp_valid = 1'b0;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      bad += int'(waddr_valid) + int'(repair_resolved) + int'(read_repair_req_acq);
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL midreset_late_resp: got %0d activity cycles required 0", bad);
    end
    $display("reset_mid_op: done");
  endtask

`ifdef DCACHE_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [BB-1:0] d;
    logic [AW-1:0] a;
    int wait_cycles;
    d = rand_block();
    a = $urandom;
    missed_addr = a;
    l2_req_ready = 1'b1;
    read_repair_request = 1'b1;
    sb_q.push_back('{is_write: 1'b0, addr: align(a), data: d});
    @(negedge clk);
    read_repair_request = 1'b0;
    wait_cycles = 0;
    for (int i = 0; i < TO + 4; i++) begin
      @(negedge clk);
      if (l2_req_valid) break;
      wait_cycles++;
    end
    n_checks++;
    if (wait_cycles != TO) begin
      n_fail++;
      $display("FAIL timeout_reissue: got %0d wait cycles required %0d", wait_cycles, TO);
    end
    n_checks++;
    if ({timeout_err, l2_req_addr} !== {1'b1, align(a)}) begin
      n_fail++;
      $display("FAIL timeout_err_addr: got err=%b addr=%h required 1 %h", timeout_err,
               l2_req_addr, align(a));
    end
    @(negedge clk);
    l2_resp_valid = 1'b1;
    l2_resp_data = d;
    @(negedge clk);
    l2_resp_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({repair_resolved, timeout_err} !== 2'b11) begin
      n_fail++;
      $display("FAIL timeout_complete: got res=%b err=%b required 1 1", repair_resolved,
               timeout_err);
    end
    @(negedge clk);
    $display("timeout: wait_cycles=%0d", wait_cycles);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_read_miss();
    test_write_then_read();
    test_round_robin();
    test_stray_resp();
    test_reset_mid_op();
`ifdef DCACHE_ARB_TIMEOUT_EN
    test_timeout();
`endif
    repeat (2) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
